// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute-stage ALU with a valid/ready handshake on both sides. One operation
// is in flight at a time. The result, zero flag and illegal flag are
// registered and held in DONE until the consumer takes them, so the stage
// stalls cleanly under backpressure.
//
// Optional feature, selected by the macro ALU_SERIAL_SHIFT_EN:
//   When defined, codes 100 (sll) and 110 (srl) run on a serial shifter that
//   moves one bit per cycle. A shift by k takes k+1 cycles from accept to
//   out_valid.
//   When undefined, 100 and 110 are reported as illegal, just like 111. No
//   shifter, counter or SHIFT state is built in that case.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operand/op presented by the upstream stage
//   in_ready     stage can accept (high only in IDLE)
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt,
//                100 sll, 110 srl (optional), 111 reserved
//   src_a        operand A
//   src_b        operand B; the shift amount is src_b[SHW-1:0]
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts the result
//   result       registered result
//   zero         registered (result == 0)
//   illegal_op   alu_control was unsupported
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             is_shift_op;
  logic [SHW-1:0]   shamt;

  assign is_shift_op = (alu_control == 3'b100) || (alu_control == 3'b110);
  assign shamt       = src_b[SHW-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             sub_ovf_c;
  logic             slt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ill_c;

  assign sum_c  = src_a + src_b;
  assign diff_c = src_a - src_b;

  // a < b (signed) is the sign of a-b, corrected when the subtraction
  // overflowed. Overflow happens only when the operand signs differ and the
  // sign of the difference disagrees with the sign of a.
  assign sub_ovf_c = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                     (diff_c[WIDTH-1] != src_a[WIDTH-1]);
  assign slt_c     = diff_c[WIDTH-1] ^ sub_ovf_c;

  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (alu_control)
      3'b000:  alu_res_c = sum_c;
      3'b001:  alu_res_c = diff_c;
      3'b010:  alu_res_c = src_a & src_b;
      3'b011:  alu_res_c = src_a | src_b;
      3'b101:  alu_res_c = {{(WIDTH-1){1'b0}}, slt_c};
      // Reserved codes, and the shift codes when no shifter is built, give a
      // zero result with the illegal flag raised.
      default: alu_ill_c = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_SERIAL_SHIFT_EN
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SERIAL_SHIFT_EN
          if (is_shift_op) begin
            work_d = src_a;
            cnt_d  = shamt;
            left_d = ~alu_control[1];
            if (shamt == '0) begin
              // A zero-length shift completes like a single-cycle op.
              result_d  = src_a;
              zero_d    = (src_a == '0);
              illegal_d = 1'b0;
              state_d   = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            result_d  = alu_res_c;
            zero_d    = (alu_res_c == '0);
            illegal_d = alu_ill_c;
            state_d   = S_DONE;
          end
`else
          result_d  = alu_res_c;
          zero_d    = (alu_res_c == '0);
          illegal_d = alu_ill_c;
          state_d   = S_DONE;
`endif
        end
      end

`ifdef ALU_SERIAL_SHIFT_EN
      S_SHIFT: begin
        work_d = left_q ? (work_q << 1) : (work_q >> 1);
        cnt_d  = cnt_q - SHW'(1);
        // The visible result registers stay untouched until the last shift,
        // so result/zero/illegal_op only change at completion.
        if (cnt_q == SHW'(1)) begin
          result_d  = work_d;
          zero_d    = (work_d == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      work_q    <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_SERIAL_SHIFT_EN
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule
